// File: rtl/piso_serializer_4bits_pkg.sv
// Shared types and constants for the serial shift-register link
// (transmit serializer and any receiving end).
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_RIGHT = 1'b0;  // LSB first
  localparam logic DIR_LEFT  = 1'b1;  // MSB first

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer_4bits_if.sv
// Word-load handshake and serial output bundle of the serializer.
interface piso_serializer_4bits_if
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] D;
  logic             SENS;
  logic             LOAD;
  logic             READY;
  logic             SO;
  logic             SO_EN;
  logic             DONE;

  // LOAD is valid, READY is ready. A word (D, SENS) transfers on a rising
  // edge where LOAD && READY. LOAD while READY is low is dropped, not held.
  modport master (
    output D, SENS, LOAD,
    input  READY, SO, SO_EN, DONE
  );

  modport slave (
    input  D, SENS, LOAD,
    output READY, SO, SO_EN, DONE
  );

endinterface

// File: rtl/piso_serializer_4bits_bit_counter.sv
// Mod-WIDTH bit counter with synchronous clear and enable; clear wins over enable.
module bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= last_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer_4bits.sv
// Parallel-in serial-out transmitter: accepts one WIDTH-bit word per handshake
// and emits it one bit per clock, direction chosen per word.
module piso_serializer_4bits
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    H,
  input  logic                    RST,
  piso_serializer_4bits_if.slave  bus,
  output state_e                  state_o
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic             sens_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_bit_counter (
    .clk_i  (H),
    .rst_i  (RST),
    .clr_i  (accept),
    .en_i   (state_q == SHIFT),
    .cnt_o  (cnt),
    .last_o (last)
  );

  // Ready in IDLE and on the last bit, so held LOAD streams words with no gap.
  assign bus.READY = (state_q == IDLE) || last;
  assign accept    = bus.LOAD && bus.READY;
  assign shifted   = (sens_q == DIR_RIGHT) ? {1'b0, shreg_q[WIDTH-1:1]}
                                           : {shreg_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge H) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      sens_q  <= DIR_RIGHT;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.LOAD) begin
            shreg_q <= bus.D;
            sens_q  <= bus.SENS;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            shreg_q <= bus.D;
            sens_q  <= bus.SENS;
          end else begin
            shreg_q <= shifted;
            if (last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SO_EN = (state_q == SHIFT);
  assign bus.SO    = bus.SO_EN && ((sens_q == DIR_RIGHT) ? shreg_q[0] : shreg_q[WIDTH-1]);
  assign bus.DONE  = bus.SO_EN && last;
  assign state_o   = state_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_piso_serializer_4bits.sv
// Directed and random stimulus for the serializer at WIDTH 4 and WIDTH 8,
// checked cycle by cycle against a bit-queue model of the serial stream.
module tb_piso_serializer_4bits;
  import serializer_pkg::*;

  logic   H = 1'b0;
  logic   RST;
  state_e state4, state8;

  int checks = 0;
  int errors = 0;

  // Remaining serial bits of the word in flight, front = bit on SO now.
  logic [0:0] exp_q4[$];
  logic [0:0] exp_q8[$];
  logic [15:0] s4, s8;

  piso_serializer_4bits_if #(.WIDTH(4)) if4 ();
  piso_serializer_4bits_if #(.WIDTH(8)) if8 ();

  piso_serializer_4bits #(.WIDTH(4)) dut4 (.H(H), .RST(RST), .bus(if4), .state_o(state4));
  piso_serializer_4bits #(.WIDTH(8)) dut8 (.H(H), .RST(RST), .bus(if8), .state_o(state8));

  // clock / reset
  always #5 H = ~H;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic drive4(input logic load, input logic [3:0] d, input logic sens);
    if4.LOAD = load; if4.D = d; if4.SENS = sens;
  endtask

  task automatic drive8(input logic load, input logic [7:0] d, input logic sens);
    if8.LOAD = load; if8.D = d; if8.SENS = sens;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    logic rdy4, rdy8;
    rdy4 = (exp_q4.size() <= 1);
    rdy8 = (exp_q8.size() <= 1);
    if (RST) begin
      exp_q4.delete();
      exp_q8.delete();
    end else begin
      if (exp_q4.size() > 0) void'(exp_q4.pop_front());
      if (exp_q8.size() > 0) void'(exp_q8.pop_front());
      if (if4.LOAD && rdy4)
        for (int i = 0; i < 4; i++) exp_q4.push_back(if4.SENS ? if4.D[3-i] : if4.D[i]);
      if (if8.LOAD && rdy8)
        for (int i = 0; i < 8; i++) exp_q8.push_back(if8.SENS ? if8.D[7-i] : if8.D[i]);
    end
    @(posedge H);
    #1;
    check_bit("so4",    if4.SO,    exp_q4.size() > 0 ? exp_q4[0][0] : 1'b0);
    check_bit("so_en4", if4.SO_EN, exp_q4.size() > 0);
    check_bit("done4",  if4.DONE,  exp_q4.size() == 1);
    check_bit("ready4", if4.READY, exp_q4.size() <= 1);
    check_bit("state4", state4 == SHIFT, exp_q4.size() > 0);
    check_bit("so8",    if8.SO,    exp_q8.size() > 0 ? exp_q8[0][0] : 1'b0);
    check_bit("so_en8", if8.SO_EN, exp_q8.size() > 0);
    check_bit("done8",  if8.DONE,  exp_q8.size() == 1);
    check_bit("ready8", if8.READY, exp_q8.size() <= 1);
    if (if4.SO_EN) s4 = {s4[14:0], if4.SO};
    if (if8.SO_EN) s8 = {s8[14:0], if8.SO};
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RST = 1'b1;
    drive4(1'b0, 4'h0, 1'b0);
    drive8(1'b0, 8'h00, 1'b0);
    s4 = '0; s8 = '0;

    // reset, right shift of 1011
    ticks(2);
    RST = 1'b0;
    s4 = '0;
    drive4(1'b1, 4'b1011, DIR_RIGHT);
    tick();
    drive4(1'b0, 4'b0000, DIR_RIGHT);
    ticks(4);
    check_vec("right_1011", s4, 16'b1101);

    // left shift of 1011, SENS flipped mid-word
    s4 = '0;
    drive4(1'b1, 4'b1011, DIR_LEFT);
    tick();
    drive4(1'b0, 4'b1011, DIR_RIGHT);
    tick();
    drive4(1'b0, 4'b1011, DIR_LEFT);
    tick();
    drive4(1'b0, 4'b1011, DIR_RIGHT);
    ticks(3);
    check_vec("left_1011", s4, 16'b1011);

    // back-to-back A then 5 with LOAD held high
    s4 = '0;
    drive4(1'b1, 4'hA, DIR_RIGHT);
    tick();
    drive4(1'b1, 4'h5, DIR_RIGHT);
    ticks(3);
    tick();
    drive4(1'b0, 4'h0, DIR_RIGHT);
    ticks(4);
    check_vec("b2b_A5", s4, 16'b01011010);

    // load pulse while busy is dropped
    s4 = '0;
    drive4(1'b1, 4'hF, DIR_RIGHT);
    tick();
    drive4(1'b1, 4'h0, DIR_RIGHT);
    tick();
    drive4(1'b0, 4'h0, DIR_RIGHT);
    ticks(4);
    check_vec("ignored_load", s4, 16'b1111);

    // reset on the 2nd bit of C, with a same-cycle load of 3
    drive4(1'b1, 4'hC, DIR_RIGHT);
    tick();
    drive4(1'b0, 4'hC, DIR_RIGHT);
    tick();
    RST = 1'b1;
    drive4(1'b1, 4'h3, DIR_RIGHT);
    tick();
    RST = 1'b0;
    drive4(1'b0, 4'h3, DIR_RIGHT);
    tick();
    s4 = '0;
    drive4(1'b1, 4'h3, DIR_RIGHT);
    tick();
    drive4(1'b0, 4'h0, DIR_RIGHT);
    ticks(4);
    check_vec("after_reset_3", s4, 16'b1100);

    // WIDTH 8, left shift of 81
    s8 = '0;
    drive8(1'b1, 8'h81, DIR_LEFT);
    tick();
    drive8(1'b0, 8'h00, DIR_RIGHT);
    ticks(8);
    check_vec("w8_left_81", s8, 16'b10000001);

    // random traffic on both instances, occasional reset
    for (int i = 0; i < 300; i++) begin
      RST = ($urandom_range(0, 31) == 0);
      drive4(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      drive8(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    RST = 1'b0;
    drive4(1'b0, 4'h0, 1'b0);
    drive8(1'b0, 8'h00, 1'b0);
    ticks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer_4bits.md
# piso_serializer_4bits

Parallel-in, serial-out transmitter that accepts a 4-bit word through a valid/ready handshake and emits it one bit per clock. The shift direction is selectable per word. It is the transmit end of the team's serial shift-register link: its SO/SO_EN pair drives the serial input of a receiving shift register, which reassembles the word.

## Interface
Parameters:
- WIDTH, 4, word length in bits; legal range ≥ 2.

Ports:
- H  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- D  in  WIDTH  parallel word; sampled only on an accepted load.
- SENS  in  1  direction, sampled with D.
  - 0: shift right, LSB first.
  - 1: shift left, MSB first.
- LOAD  in  1  load request (valid).
- READY  out  1  block can accept a word this cycle.
- SO  out  1  serial data out; 0 whenever SO_EN = 0.
- SO_EN  out  1  SO carries a valid bit this cycle.
- DONE  out  1  one-cycle pulse, high during the last bit of a word.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - READY = 1, SO_EN = 0, SO = 0, DONE = 0.
  - LOAD = 1 at a rising edge: capture D into the shift register, capture SENS, clear the bit counter, go to SHIFT.
- SHIFT:
  - SO_EN = 1.
  - SO = shreg[0] if the captured SENS = 0, else shreg[WIDTH-1].
  - Each edge shifts the register one place toward the output end, fills the vacated bit with 0, and increments the counter.
- Last bit (counter = WIDTH-1):
  - DONE = 1 and READY = 1.
  - At that edge, LOAD = 1: capture the new D/SENS, stay in SHIFT, clear the counter (back-to-back, no gap cycle).
  - At that edge, LOAD = 0: go to IDLE.
- LOAD while READY = 0 is ignored. No queuing, no error flag. D and SENS changes during SHIFT have no effect.
- SENS is frozen per word. Changing SENS mid-word never alters bit order.
- Counter is $clog2(WIDTH) bits, wraps to 0 on every load, and never exceeds WIDTH-1.
- Reset:
  - RST = 1 at an edge forces IDLE, shreg = 0, counter = 0, captured SENS = 0.
  - Reset takes priority over LOAD, including in the same cycle.
  - Reset mid-word aborts the word: no DONE, and the partial bits are not resumed.
- Reset output values: READY = 1, SO = 0, SO_EN = 0, DONE = 0.

## Timing
- LOAD accepted at edge k: bit 0 of the serial stream appears during cycle k→k+1, and bit i during cycle k+i→k+i+1.
- DONE coincides with bit WIDTH-1 (cycle k+WIDTH-1→k+WIDTH).
- Throughput: one word per WIDTH cycles when LOAD is held high. SO_EN stays continuously high.
- READY, SO, SO_EN and DONE are decoded from registered state only. There is no combinational path from any input to any output.
- The receiver samples SO on the rising edge of H when SO_EN = 1.

## Structure
- Package serializer_pkg holds:
  - the state enum (IDLE, SHIFT);
  - DIR_RIGHT = 1'b0 and DIR_LEFT = 1'b1;
  - the default WIDTH constant.
- One sub-module is natural: bit_counter, a mod-WIDTH counter with synchronous clear and enable, also reusable by the receiving end.
- Everything else sits in a single clocked process plus an output decode.

## Test plan
- Reset, right shift: RST for 2 cycles, then LOAD with D = 4'b1011, SENS = 0.
  - SO = 1,1,0,1 over 4 cycles with SO_EN = 1.
  - DONE only on the 4th bit; READY = 0 on bits 1-3.
- Left shift: D = 4'b1011, SENS = 1.
  - SO = 1,0,1,1.
  - SENS toggled mid-word does not change the sequence.
- Back-to-back: LOAD held high with D = 4'hA then 4'h5, SENS = 0.
  - SO = 0,1,0,1,1,0,1,0 with no gap.
  - SO_EN high for 8 consecutive cycles; DONE on cycles 4 and 8.
- Ignored load: during the 2nd bit of 4'hF, pulse LOAD with D = 4'h0.
  - Stream stays 1,1,1,1; the block returns to IDLE after DONE.
- Mid-word reset: RST on the 2nd bit of 4'hC.
  - Next cycle: SO = 0, SO_EN = 0, DONE = 0, READY = 1.
  - LOAD 4'h3 sent together with RST is dropped; a fresh LOAD afterwards yields 1,1,0,0.
- WIDTH = 8 instance, D = 8'h81, SENS = 1.
  - SO = 1,0,0,0,0,0,0,1; DONE on the 8th bit.
